// File: rtl/fighter_pkg.sv
// Shared encodings and default constants for the fighter game-state stage and
// the pixel stage that draws from it.
package fighter_pkg;

    localparam int X_W      = 10;
    localparam int HEALTH_W = 7;
    localparam int CNT_W    = 4;

    localparam int X_INIT_DEF         = 160;
    localparam int X_MIN_DEF          = 16;
    localparam int X_MAX_DEF          = 576;
    localparam int WALK_STEP_DEF      = 4;
    localparam int MIN_GAP_DEF        = 32;
    localparam int REACH_DEF          = 64;
    localparam int WINDUP_FRAMES_DEF  = 3;
    localparam int ACTIVE_FRAMES_DEF  = 2;
    localparam int RECOVER_FRAMES_DEF = 6;
    localparam int STUN_FRAMES_DEF    = 15;
    localparam int HEALTH_MAX_DEF     = 100;
    localparam int DAMAGE_DEF         = 10;
    localparam int BLOCK_DAMAGE_DEF   = 2;

    // Nine behavioural states share eight codes: left and right walking report
    // as WALK, the direction being visible from x_pos itself.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WALK       = 3'd1,
        PUNCH_WIND = 3'd2,
        PUNCH_ACT  = 3'd3,
        PUNCH_REC  = 3'd4,
        BLOCK      = 3'd5,
        STUNNED    = 3'd6,
        KO         = 3'd7
    } fighter_state_e;

    function automatic logic [X_W:0] abs_diff(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/fighter_move_clamp.sv
// Next x for one walking step: screen-range clamp, then minimum-gap clamp when
// stepping toward the opponent.
module fighter_move_clamp
    import fighter_pkg::*;
#(
    parameter int X_MIN     = X_MIN_DEF,
    parameter int X_MAX     = X_MAX_DEF,
    parameter int WALK_STEP = WALK_STEP_DEF,
    parameter int MIN_GAP   = MIN_GAP_DEF
) (
    input  logic [X_W-1:0] x_i,
    input  logic           left_i,
    input  logic [X_W-1:0] opp_x_i,
    input  logic           facing_right_i,
    output logic [X_W-1:0] x_o
);

    localparam logic [X_W:0] STEP_W  = (X_W+1)'(WALK_STEP);
    localparam logic [X_W:0] GAP_W   = (X_W+1)'(MIN_GAP);
    localparam logic [X_W:0] X_LO    = (X_W+1)'(X_MIN);
    localparam logic [X_W:0] X_HI    = (X_W+1)'(X_MAX);
    localparam logic [X_W:0] LO_STEP = (X_W+1)'(X_MIN + WALK_STEP);

    logic [X_W:0]   x_w;
    logic [X_W:0]   opp_w;
    logic [X_W:0]   stepped;
    logic [X_W:0]   gap_lim;
    logic [X_W-1:0] x_next;

    always_comb begin
        x_w     = {1'b0, x_i};
        opp_w   = {1'b0, opp_x_i};
        gap_lim = '0;
        if (left_i) begin
            stepped = (x_w >= LO_STEP) ? x_w - STEP_W : X_LO;
        end else begin
            stepped = (x_w + STEP_W <= X_HI) ? x_w + STEP_W : X_HI;
        end
        x_next = X_W'(stepped);

        // A gap limit that lies behind the current x means we are already too
        // close: hold rather than get pushed backward.
        if (left_i && !facing_right_i) begin
            gap_lim = opp_w + GAP_W;
            if (stepped < gap_lim) begin
                x_next = (gap_lim > x_w) ? x_i : X_W'(gap_lim);
            end
        end else if (!left_i && facing_right_i) begin
            gap_lim = (opp_w >= GAP_W) ? opp_w - GAP_W : '0;
            if (stepped > gap_lim) begin
                x_next = (gap_lim < x_w) ? x_i : X_W'(gap_lim);
            end
        end
        x_o = x_next;
    end

endmodule

// File: rtl/fighter_controller.sv
// Per-fighter state machine: buttons and opponent hits in, position, action
// state, health and KO out; advances once per frame_tick.
module fighter_controller
    import fighter_pkg::*;
#(
    parameter int X_INIT         = X_INIT_DEF,
    parameter int X_MIN          = X_MIN_DEF,
    parameter int X_MAX          = X_MAX_DEF,
    parameter int WALK_STEP      = WALK_STEP_DEF,
    parameter int MIN_GAP        = MIN_GAP_DEF,
    parameter int REACH          = REACH_DEF,
    parameter int FACING_RIGHT   = 1,
    parameter int WINDUP_FRAMES  = WINDUP_FRAMES_DEF,
    parameter int ACTIVE_FRAMES  = ACTIVE_FRAMES_DEF,
    parameter int RECOVER_FRAMES = RECOVER_FRAMES_DEF,
    parameter int STUN_FRAMES    = STUN_FRAMES_DEF,
    parameter int HEALTH_MAX     = HEALTH_MAX_DEF,
    parameter int DAMAGE         = DAMAGE_DEF,
    parameter int BLOCK_DAMAGE   = BLOCK_DAMAGE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_punch,
    input  logic                btn_block,
    input  logic                hit_in,
    input  logic [X_W-1:0]      opp_x,
    output logic [X_W-1:0]      x_pos,
    output logic [2:0]          state,
    output logic [HEALTH_W-1:0] health,
    output logic                punch_active,
    output logic                hit_out,
    output logic                ko
);

    localparam logic [CNT_W-1:0]    WIND_LAST = CNT_W'(WINDUP_FRAMES - 1);
    localparam logic [CNT_W-1:0]    ACT_LAST  = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]    REC_LAST  = CNT_W'(RECOVER_FRAMES - 1);
    localparam logic [CNT_W-1:0]    STUN_LAST = CNT_W'(STUN_FRAMES - 1);
    localparam logic [HEALTH_W-1:0] H_MAX     = HEALTH_W'(HEALTH_MAX);
    localparam logic [HEALTH_W-1:0] DMG       = HEALTH_W'(DAMAGE);
    localparam logic [HEALTH_W-1:0] BLK_DMG   = HEALTH_W'(BLOCK_DAMAGE);
    localparam logic [X_W-1:0]      X_RST     = X_W'(X_INIT);
    localparam logic [X_W:0]        REACH_W   = (X_W+1)'(REACH);

    function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                    input logic [HEALTH_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    fighter_state_e      state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [X_W-1:0]      x_q;
    logic [HEALTH_W-1:0] health_q;
    logic                pact_q;
    logic                hit_q;
    logic                ko_q;
    logic                pend_q;

    logic                hit_now;
    logic                walk_left;
    logic                walk_right;
    logic                in_reach;
    logic [HEALTH_W-1:0] health_d;
    logic [X_W-1:0]      x_walk_d;

    always_comb begin
        hit_now    = pend_q | hit_in;
        walk_left  = btn_left & ~btn_right;
        walk_right = btn_right & ~btn_left;
        in_reach   = (abs_diff(x_q, opp_x) <= REACH_W);
        health_d   = sat_sub(health_q, (state_q == BLOCK) ? BLK_DMG : DMG);
    end

    fighter_move_clamp #(
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .WALK_STEP(WALK_STEP),
        .MIN_GAP  (MIN_GAP)
    ) u_clamp (
        .x_i           (x_q),
        .left_i        (walk_left),
        .opp_x_i       (opp_x),
        .facing_right_i(FACING_RIGHT != 0),
        .x_o           (x_walk_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= X_RST;
            health_q <= H_MAX;
            pact_q   <= 1'b0;
            hit_q    <= 1'b0;
            ko_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (!frame_tick) begin
                if (hit_in) pend_q <= 1'b1;
            end else begin
                pend_q <= 1'b0;
                if (state_q == KO) begin
                    // frozen until reset
                end else if (hit_now) begin
                    health_q <= health_d;
                    pact_q   <= 1'b0;
                    if (health_d == '0) begin
                        state_q <= KO;
                        ko_q    <= 1'b1;
                    end else if (state_q != BLOCK) begin
                        state_q <= STUNNED;
                        cnt_q   <= STUN_LAST;
                    end
                end else if (state_q inside {PUNCH_WIND, PUNCH_ACT, PUNCH_REC, STUNNED}) begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        case (state_q)
                            PUNCH_WIND: begin
                                state_q <= PUNCH_ACT;
                                cnt_q   <= ACT_LAST;
                                pact_q  <= 1'b1;
                                hit_q   <= in_reach;
                            end
                            PUNCH_ACT: begin
                                state_q <= PUNCH_REC;
                                cnt_q   <= REC_LAST;
                                pact_q  <= 1'b0;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end else begin
                    if (btn_punch) begin
                        state_q <= PUNCH_WIND;
                        cnt_q   <= WIND_LAST;
                    end else if (btn_block) begin
                        state_q <= BLOCK;
                    end else if (walk_left || walk_right) begin
                        state_q <= WALK;
                        x_q     <= x_walk_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

    assign x_pos        = x_q;
    assign state        = state_q;
    assign health       = health_q;
    assign punch_active = pact_q;
    assign hit_out      = hit_q;
    assign ko           = ko_q;

endmodule

// File: tb/tb_fighter_controller.sv
// Directed scenarios plus randomized play, checked every cycle against a
// frame-level behavioural model of one fighter.
module tb_fighter_controller;
    import fighter_pkg::*;

    localparam bit FACING = 1'b1;
    localparam bit [3:0] B_NONE  = 4'b0000;   // {punch, block, left, right}
    localparam bit [3:0] B_RIGHT = 4'b0001;
    localparam bit [3:0] B_LEFT  = 4'b0010;
    localparam bit [3:0] B_BLOCK = 4'b0100;
    localparam bit [3:0] B_PUNCH = 4'b1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, frame_tick = 1'b0, hit_in = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_punch = 1'b0, btn_block = 1'b0;
    logic [9:0] opp_x = 10'd300;
    logic [9:0] x_pos;
    logic [2:0] state;
    logic [6:0] health;
    logic punch_active, hit_out, ko;

    fighter_controller dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_punch(btn_punch),
        .btn_block(btn_block), .hit_in(hit_in), .opp_x(opp_x),
        .x_pos(x_pos), .state(state), .health(health),
        .punch_active(punch_active), .hit_out(hit_out), .ko(ko)
    );

    int n_checks = 0;
    int n_errors = 0;
    int hit_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame-level model: timed phases count remaining frames down to zero.
    fighter_state_e m_state;
    int m_x, m_health, m_left;
    bit m_pend, m_hit, m_pact, m_ko;

    function automatic int walk_to(int x, bit right, int opp);
        int nx;
        nx = right ? x + 4 : x - 4;
        if (nx < 16) nx = 16;
        if (nx > 576) nx = 576;
        if (right && FACING) begin
            if (nx > opp - 32) nx = opp - 32;
            if (nx < x) nx = x;
        end else if (!right && !FACING) begin
            if (nx < opp + 32) nx = opp + 32;
            if (nx > x) nx = x;
        end
        return nx;
    endfunction

    task automatic model_clock();
        bit pend;
        int d;
        if (reset) begin
            m_x = 160; m_state = IDLE; m_health = 100; m_left = 0;
            m_pend = 0; m_hit = 0; m_pact = 0; m_ko = 0;
            return;
        end
        pend = m_pend || hit_in;
        m_hit = 0;
        if (!frame_tick) begin
            m_pend = pend;
            return;
        end
        m_pend = 0;
        if (m_state == KO) return;
        if (pend) begin
            m_health -= (m_state == BLOCK) ? 2 : 10;
            if (m_health < 0) m_health = 0;
            if (m_state != BLOCK) begin m_state = STUNNED; m_left = 15; end
            if (m_health == 0) begin m_state = KO; m_ko = 1; end
        end else if (m_state inside {PUNCH_WIND, PUNCH_ACT, PUNCH_REC, STUNNED}) begin
            m_left--;
            if (m_left == 0) begin
                case (m_state)
                    PUNCH_WIND: begin
                        m_state = PUNCH_ACT; m_left = 2;
                        d = m_x - int'(opp_x);
                        if (d < 0) d = -d;
                        m_hit = (d <= 64);
                    end
                    PUNCH_ACT: begin m_state = PUNCH_REC; m_left = 6; end
                    default:   m_state = IDLE;
                endcase
            end
        end else if (btn_punch) begin
            m_state = PUNCH_WIND; m_left = 3;
        end else if (btn_block) begin
            m_state = BLOCK;
        end else if (btn_left != btn_right) begin
            m_state = WALK;
            m_x = walk_to(m_x, btn_right, int'(opp_x));
        end else begin
            m_state = IDLE;
        end
        m_pact = (m_state == PUNCH_ACT);
    endtask

    task automatic cycle(input bit tk, input bit rst, input bit [3:0] btn, input bit hi);
        @(negedge clk);
        frame_tick = tk; reset = rst; hit_in = hi;
        {btn_punch, btn_block, btn_left, btn_right} = btn;
        @(posedge clk);
        model_clock();
        #1;
        if (hit_out === 1'b1) hit_pulses++;
        check("x_pos", x_pos, m_x);
        check("state", state, m_state);
        check("health", health, m_health);
        check("punch_active", punch_active, m_pact);
        check("hit_out", hit_out, m_hit);
        check("ko", ko, m_ko);
    endtask

    task automatic tick(input bit [3:0] btn, input bit hit_tk, input bit hit_mid);
        cycle(1'b1, 1'b0, btn, hit_tk);
        cycle(1'b0, 1'b0, btn, hit_mid);
        cycle(1'b0, 1'b0, btn, hit_mid);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1, B_NONE, 1'b0);
        cycle(1'b0, 1'b0, B_NONE, 1'b0);
    endtask

    fighter_state_e exp_seq [12];

    initial begin
        exp_seq = '{PUNCH_WIND, PUNCH_WIND, PUNCH_WIND, PUNCH_ACT, PUNCH_ACT,
                    PUNCH_REC, PUNCH_REC, PUNCH_REC, PUNCH_REC, PUNCH_REC,
                    PUNCH_REC, IDLE};

        // Reset and idle frames
        do_reset();
        check("rst_x", x_pos, 160);
        check("rst_state", state, IDLE);
        check("rst_health", health, 100);
        check("rst_ko", ko, 0);
        for (int i = 0; i < 5; i++) tick(B_NONE, 1'b0, 1'b0);
        check("idle_x", x_pos, 160);
        check("idle_state", state, IDLE);

        // Walk right toward opponent, then into the gap clamp
        opp_x = 10'd300;
        for (int i = 0; i < 10; i++) tick(B_RIGHT, 1'b0, 1'b0);
        check("walk10_x", x_pos, 200);
        for (int i = 0; i < 25; i++) tick(B_RIGHT, 1'b0, 1'b0);
        check("gap_clamp_x", x_pos, 268);
        check("gap_clamp_state", state, WALK);
        for (int i = 0; i < 70; i++) tick(B_LEFT, 1'b0, 1'b0);
        check("left_edge_x", x_pos, 16);

        // Punch in reach, then out of reach
        for (int r = 0; r < 2; r++) begin
            do_reset();
            opp_x = (r == 0) ? 10'd200 : 10'd300;
            hit_pulses = 0;
            for (int i = 0; i < 12; i++) begin
                tick(B_PUNCH, 1'b0, 1'b0);
                check($sformatf("punch%0d_seq%0d", r, i), state, exp_seq[i]);
            end
            tick(B_NONE, 1'b0, 1'b0);
            check($sformatf("punch%0d_hits", r), hit_pulses, (r == 0) ? 1 : 0);
        end

        // Hit during wind-up stuns and cancels the punch
        do_reset();
        opp_x = 10'd200;
        hit_pulses = 0;
        tick(B_PUNCH, 1'b0, 1'b0);
        tick(B_NONE, 1'b0, 1'b1);
        tick(B_NONE, 1'b0, 1'b0);
        check("stun_health", health, 90);
        check("stun_state", state, STUNNED);
        for (int i = 0; i < 14; i++) tick(B_NONE, 1'b0, 1'b0);
        check("stun_last", state, STUNNED);
        tick(B_NONE, 1'b0, 1'b0);
        check("stun_exit", state, IDLE);
        check("stun_no_hit", hit_pulses, 0);

        // Blocked hit
        do_reset();
        tick(B_BLOCK, 1'b0, 1'b0);
        tick(B_BLOCK, 1'b0, 1'b1);
        tick(B_BLOCK, 1'b0, 1'b0);
        check("block_health", health, 98);
        check("block_state", state, BLOCK);

        // Ten hits, including repeats inside one frame, reach KO
        do_reset();
        for (int i = 0; i < 10; i++) tick(B_NONE, 1'b1, 1'b1);
        check("ko_health", health, 0);
        check("ko_flag", ko, 1);
        check("ko_state", state, KO);
        for (int i = 0; i < 4; i++) tick(B_PUNCH | B_RIGHT, 1'b1, 1'b1);
        check("ko_hold_state", state, KO);
        check("ko_hold_x", x_pos, 160);
        cycle(1'b0, 1'b1, B_NONE, 1'b0);
        check("ko_rst_state", state, IDLE);
        check("ko_rst_health", health, 100);
        check("ko_rst_ko", ko, 0);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            bit [3:0] b;
            bit tk, rst, hi;
            if ($urandom_range(0, 15) == 0) opp_x = 10'($urandom_range(0, 700));
            b   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) b[3] = 1'b0;
            tk  = ($urandom_range(0, 2) == 0);
            hi  = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 399) == 0) || (ko === 1'b1 && $urandom_range(0, 29) == 0);
            cycle(tk, rst, b, hi);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fighter_controller.md
Name: fighter_controller

Overview:
- Per-fighter game-state stage that sits directly upstream of the pixel colouring logic (vga_bitchange).
- Turns debounced button levels and opponent hit events into fighter x position, action state, health and KO flag.
- The pixel stage draws sprites and health bars from these outputs.
- State advances only on a once-per-frame tick; positions are therefore stable for the entire visible frame.
- Two instances are used, one per player; each instance's hit_out feeds the other's hit_in.

Parameters:
- X_INIT, 160, x position after reset (pixels).
- X_MIN, 16, leftmost legal x.
- X_MAX, 576, rightmost legal x.
- WALK_STEP, 4, pixels moved per frame while walking.
- MIN_GAP, 32, minimum allowed |x_pos - opp_x| when walking toward the opponent.
- REACH, 64, maximum |x_pos - opp_x| at which a punch connects.
- FACING_RIGHT, 1, 1 = opponent is to the right.
- WINDUP_FRAMES, 3, frames spent in PUNCH_WIND.
- ACTIVE_FRAMES, 2, frames spent in PUNCH_ACT.
- RECOVER_FRAMES, 6, frames spent in PUNCH_REC.
- STUN_FRAMES, 15, frames spent in STUNNED.
- HEALTH_MAX, 100, health after reset.
- DAMAGE, 10, health lost to an unblocked hit.
- BLOCK_DAMAGE, 2, health lost to a blocked hit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per frame (at vCount wrap).
- btn_left  in  1  debounced level.
- btn_right  in  1  debounced level.
- btn_punch  in  1  debounced level.
- btn_block  in  1  debounced level.
- hit_in  in  1  one-cycle pulse: opponent's punch connected.
- opp_x  in  10  opponent x position.
- x_pos  out  10  fighter x position.
- state  out  3  current action state (encoding in package).
- health  out  7  remaining health.
- punch_active  out  1  high while state == PUNCH_ACT.
- hit_out  out  1  one-cycle pulse: this fighter's punch connected.
- ko  out  1  sticky; high once health reaches 0.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-punch or stun):
  - x_pos = X_INIT, state = IDLE, health = HEALTH_MAX.
  - punch_active = 0, hit_out = 0, ko = 0.
  - hit_pending = 0, frame counter = 0.
- Hit latching:
  - hit_pending is set on any cycle where hit_in = 1.
  - It is cleared on the frame_tick cycle that consumes it.
  - hit_in on the same cycle as frame_tick is consumed in that frame.
  - Multiple hits within one frame count once.
- No state, position or health change occurs on cycles without frame_tick.
- States: IDLE, WALK_L, WALK_R, PUNCH_WIND, PUNCH_ACT, PUNCH_REC, BLOCK, STUNNED, KO.
- On frame_tick, the first matching rule applies:
  1. state == KO: hold all outputs; hit_pending is cleared.
  2. hit_pending while state == BLOCK: health -= BLOCK_DAMAGE, saturating at 0; state unchanged.
  3. hit_pending in any other state: health -= DAMAGE, saturating at 0; state -> STUNNED; counter = STUN_FRAMES-1. This cancels any punch phase.
  4. If the resulting health == 0: state -> KO, ko = 1. Evaluated in the same tick as rules 2 and 3.
  5. Timed states (PUNCH_WIND, PUNCH_ACT, PUNCH_REC, STUNNED) with counter != 0: counter decrements.
  6. Timed states with counter == 0:
     - PUNCH_WIND -> PUNCH_ACT (counter = ACTIVE_FRAMES-1).
     - PUNCH_ACT -> PUNCH_REC (counter = RECOVER_FRAMES-1).
     - PUNCH_REC -> IDLE.
     - STUNNED -> IDLE.
  7. Free states (IDLE, WALK_L, WALK_R, BLOCK) select by button priority:
     - punch -> PUNCH_WIND (counter = WINDUP_FRAMES-1).
     - else block -> BLOCK.
     - else left only -> WALK_L.
     - else right only -> WALK_R.
     - else (none, or left and right together) -> IDLE.
- Movement:
  - Applied in the same tick the state becomes or remains WALK_L or WALK_R. New x = x ± WALK_STEP.
  - Clamp to [X_MIN, X_MAX].
  - When moving toward the opponent, clamp to opp_x ∓ MIN_GAP.
  - Moving away from the opponent is never gap-clamped.
  - If the clamp would move the fighter backward (already closer than MIN_GAP), x holds.
  - Arithmetic uses 11-bit intermediates; no wrap-around.
- hit_out:
  - Pulses high for exactly the frame_tick cycle on which state enters PUNCH_ACT, if |x_pos - opp_x| <= REACH (11-bit absolute difference).
  - Otherwise 0.
  - One pulse per punch at most.
- punch_active is a registered output, asserted for exactly ACTIVE_FRAMES frames.
- Latency: every output updates in the cycle after the frame_tick edge.

Decomposition:
- fighter_pkg holds:
  - the state enum (3-bit, IDLE = 0, KO = 7);
  - the health and x widths;
  - shared default constants, so that both instances and vga_bitchange agree on the encoding.
- One sub-module: fighter_move_clamp. It is combinational: it takes x, direction, opp_x and facing, and returns the clamped next x. It is reused by both walk states.

Test Plan:
- Reset, then 5 ticks with no buttons -> x_pos = 160, state = IDLE, health = 100, ko = 0.
- btn_right held for 10 ticks, opp_x = 300 -> x_pos = 200. Hold until the clamp -> x_pos stops at 268.
- btn_punch held, opp_x = 200, x = 160 -> PUNCH_WIND for 3 ticks; hit_out pulses once on the 4th tick; punch_active high for 2 ticks; then 6 ticks of PUNCH_REC; then IDLE.
- Same punch with opp_x = 300 -> state sequence identical, hit_out stays 0.
- hit_in during PUNCH_WIND -> next tick health = 90, state = STUNNED for 15 ticks, no hit_out. With btn_block held beforehand -> health = 98, state stays BLOCK.
- 10 unblocked hits -> health = 0, ko = 1, state = KO. Further hits and buttons leave everything unchanged. Reset mid-KO restores all reset values in 1 cycle.
